// File: rtl/pipe_ctrl_pkg.sv
// Shared types and sizing for the DLX pipeline stall/flush controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2,
    ST_ERROR      = 2'd3
  } state_e;

  localparam int REG_W        = 5;
  localparam int LOAD_LAT_MAX = 4;
  // cnt only ever holds LOAD_LAT-1, so the legal maximum latency sizes it
  localparam int CNT_W        = $clog2(LOAD_LAT_MAX);

  // tmr counts up to MEM_TIMEOUT-1
  function automatic int tmr_width(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/pipe_ctrl_lu_detect.sv
// Load-use hazard detector: flags an ID source matching a pending load in EX.
module lu_detect #(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  output logic             hz
);

  // r0 is hard-wired zero, so a load into it never creates a dependency
  assign hz = ex_mem_read & (ex_rt != {REG_W{1'b0}}) &
              ((id_uses_rs & (id_rs == ex_rt)) | (id_uses_rt & (id_rt == ex_rt)));

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush controller for the five-stage DLX pipeline (load-use, branch squash, memory wait watchdog).
// Optional stall-cycle performance counter enabled by macro PIPE_CTRL_PERF_CNT_EN.
import pipe_ctrl_pkg::*;

module pipe_ctrl #(
  parameter int LOAD_LAT    = 1,
  parameter int MEM_TIMEOUT = 16,
  parameter int REG_W       = pipe_ctrl_pkg::REG_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             mem_err,
  output logic [31:0]      stall_count
);

  localparam int TMR_W = tmr_width(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOAD_LAT - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MEM_TIMEOUT - 1);

  state_e           state_r, state_nxt_s;
  state_e           ret_r, ret_nxt_s;
  state_e           mode_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [TMR_W-1:0] tmr_r, tmr_nxt_s;
  logic             hz_s;
  logic             busy_s;

  lu_detect #(.REG_W(REG_W)) u_lu_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .hz          (hz_s)
  );

  assign busy_s = mem_req & ~mem_ready;
  // the cycle memory becomes ready is handled by the rules of the interrupted state
  assign mode_s = (state_r == ST_MEM_WAIT) ? ret_r : state_r;

  // FSM, load-stall counter, watchdog timer and saved return state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_RUN;
      ret_r   <= ST_RUN;
      cnt_r   <= {CNT_W{1'b0}};
      tmr_r   <= {TMR_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      ret_r   <= ret_nxt_s;
      cnt_r   <= cnt_nxt_s;
      tmr_r   <= tmr_nxt_s;
    end
  end

  // next-state and Mealy output decode; priority busy > load stall > branch
  always_comb begin
    state_nxt_s = state_r;
    ret_nxt_s   = ret_r;
    cnt_nxt_s   = cnt_r;
    tmr_nxt_s   = tmr_r;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    mem_err     = 1'b0;
    if (!reset) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (state_r == ST_ERROR) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
      mem_err  = 1'b1;
    end else if (busy_s) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
      if (state_r == ST_MEM_WAIT) begin
        if (tmr_r == TMR_LAST) begin
          state_nxt_s = ST_ERROR;
        end else begin
          tmr_nxt_s = tmr_r + TMR_W'(1);
        end
      end else begin
        ret_nxt_s   = state_r;
        tmr_nxt_s   = TMR_W'(1);
        state_nxt_s = ST_MEM_WAIT;
      end
    end else if (mode_s == ST_LOAD_STALL) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      cnt_nxt_s  = cnt_r - CNT_W'(1);
      if (cnt_r <= CNT_W'(1)) begin
        state_nxt_s = ST_RUN;
      end else begin
        state_nxt_s = ST_LOAD_STALL;
      end
    end else begin
      state_nxt_s = ST_RUN;
      if (hz_s) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
        if (LOAD_LAT > 1) begin
          cnt_nxt_s   = CNT_INIT;
          state_nxt_s = ST_LOAD_STALL;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end else if (branch_taken) begin
        ifid_flush = 1'b1;
      end else begin
        ifid_flush = 1'b0;
      end
    end
  end

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] stall_cnt_r;

  // saturating count of cycles with the PC held
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_r <= 32'd0;
    end else if (!pc_en && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_count = stall_cnt_r;
`else
  assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: LOAD_LAT=1 and LOAD_LAT=3 instances against a cycle-level reference model.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rs, id_uses_rt, ex_mem_read, branch_taken, mem_req, mem_ready;

  logic        a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_iff, a_idf, a_err;
  logic        b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_iff, b_idf, b_err;
  logic [31:0] a_sc, b_sc;

  int tests_run    = 0;
  int tests_failed = 0;

  // reference model state, index 0 = LOAD_LAT 1, index 1 = LOAD_LAT 3
  int     ll [2] = '{1, 3};
  int     m_rem [2];
  int     m_busy_run [2];
  bit     m_err [2];
  longint m_cnt [2];

  localparam int TIMEOUT = 16;

  always #5 clk = ~clk;

  pipe_ctrl #(.LOAD_LAT(1), .MEM_TIMEOUT(TIMEOUT), .REG_W(5)) u_l1 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt), .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(a_pc), .ifid_en(a_ifid), .idex_en(a_idex), .exmem_en(a_exmem), .memwb_en(a_memwb),
    .ifid_flush(a_iff), .idex_flush(a_idf), .mem_err(a_err), .stall_count(a_sc)
  );

  pipe_ctrl #(.LOAD_LAT(3), .MEM_TIMEOUT(TIMEOUT), .REG_W(5)) u_l3 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt), .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(b_pc), .ifid_en(b_ifid), .idex_en(b_idex), .exmem_en(b_exmem), .memwb_en(b_memwb),
    .ifid_flush(b_iff), .idex_flush(b_idf), .mem_err(b_err), .stall_count(b_sc)
  );

  // output vectors ordered {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush, mem_err}
  localparam logic [7:0] V_NORMAL = 8'b1111_1000;
  localparam logic [7:0] V_BRANCH = 8'b1111_1100;
  localparam logic [7:0] V_STALL  = 8'b0011_1010;
  localparam logic [7:0] V_FREEZE = 8'b0000_0000;
  localparam logic [7:0] V_ERROR  = 8'b0000_0001;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_count(input int i);
`ifdef PIPE_CTRL_PERF_CNT_EN
    return (m_cnt[i] > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_cnt[i][31:0];
`else
    return 32'd0;
`endif
  endfunction

  // one clock cycle: compare outputs for current inputs, then advance the model
  task automatic step(input string tag);
    logic [7:0]  obs [2];
    logic [31:0] sc  [2];
    logic [7:0]  e;
    bit hz, busy;
    hz   = ex_mem_read && (ex_rt != 5'd0) &&
           ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
    busy = mem_req && !mem_ready;
    #2;
    obs[0] = {a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_iff, a_idf, a_err};
    obs[1] = {b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_iff, b_idf, b_err};
    sc[0]  = a_sc;
    sc[1]  = b_sc;
    for (int i = 0; i < 2; i++) begin
      if (m_err[i]) begin
        e = V_ERROR;
      end else if (busy) begin
        e = V_FREEZE;
        m_busy_run[i]++;
        if (m_busy_run[i] == TIMEOUT) m_err[i] = 1'b1;
      end else begin
        m_busy_run[i] = 0;
        if (m_rem[i] > 0) begin
          e = V_STALL;
          m_rem[i]--;
        end else if (hz) begin
          e = V_STALL;
          m_rem[i] = ll[i] - 1;
        end else if (branch_taken) begin
          e = V_BRANCH;
        end else begin
          e = V_NORMAL;
        end
      end
      check($sformatf("%s/L%0d/outs", tag, ll[i]), {24'd0, obs[i]}, {24'd0, e});
      check($sformatf("%s/L%0d/stall_count", tag, ll[i]), sc[i], exp_count(i));
      if (!e[7]) m_cnt[i]++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
    branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    check("reset/L1/outs", {24'd0, a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_iff, a_idf, a_err}, 32'd0);
    check("reset/L3/outs", {24'd0, b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_iff, b_idf, b_err}, 32'd0);
    check("reset/L1/stall_count", a_sc, 32'd0);
    check("reset/L3/stall_count", b_sc, 32'd0);
    for (int i = 0; i < 2; i++) begin
      m_rem[i] = 0; m_busy_run[i] = 0; m_err[i] = 1'b0; m_cnt[i] = 0;
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic set_hazard(input logic [4:0] rt);
    ex_mem_read = 1'b1; ex_rt = rt; id_rs = 5'd8; id_uses_rs = 1'b1;
  endtask

  initial begin
    logic [31:0] perf_exp;
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;
    do_reset();
    step("first_run");

    // load-use hazard on r8, then the same pattern targeting r0
    set_hazard(5'd8);
    step("lu_r8");
    ex_mem_read = 1'b0;
    for (int k = 0; k < 3; k++) step("lu_r8_tail");
    set_hazard(5'd0);
    step("lu_r0");
    idle_inputs();
    for (int k = 0; k < 2; k++) step("lu_r0_tail");

    // hazard held three cycles with a taken branch present the whole time
    set_hazard(5'd8);
    branch_taken = 1'b1;
    for (int k = 0; k < 3; k++) step("lu_branch");
    idle_inputs();
    step("lu_branch_done");

    branch_taken = 1'b1;
    step("branch");
    branch_taken = 1'b0;
    step("branch_done");

    // five busy cycles then ready
    mem_req = 1'b1;
    for (int k = 0; k < 5; k++) step("busy5");
    mem_ready = 1'b1;
    step("busy5_ready");
    idle_inputs();

    // memory wait arriving in the middle of a load stall
    set_hazard(5'd8);
    step("ls_busy_hz");
    idle_inputs();
    mem_req = 1'b1;
    for (int k = 0; k < 2; k++) step("ls_busy_wait");
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) step("ls_busy_resume");
    idle_inputs();

    // perf scenario: three-cycle hazard then five-cycle wait
    do_reset();
    set_hazard(5'd8);
    for (int k = 0; k < 3; k++) step("perf_lu");
    idle_inputs();
    mem_req = 1'b1;
    for (int k = 0; k < 5; k++) step("perf_wait");
    idle_inputs();
`ifdef PIPE_CTRL_PERF_CNT_EN
    perf_exp = 32'd8;
`else
    perf_exp = 32'd0;
`endif
    check("perf_total_L3", b_sc, perf_exp);

    // randomized traffic on a small register set so hazards are common
    for (int k = 0; k < 400; k++) begin
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      ex_rt        = 5'($urandom_range(0, 3));
      id_uses_rs   = 1'($urandom_range(0, 1));
      id_uses_rt   = 1'($urandom_range(0, 1));
      ex_mem_read  = ($urandom_range(0, 2) == 0);
      branch_taken = ($urandom_range(0, 3) == 0);
      mem_req      = ($urandom_range(0, 2) == 0);
      mem_ready    = ($urandom_range(0, 1) == 0);
      step("random");
    end
    idle_inputs();

    // watchdog: sixteen busy cycles trip the sticky error
    do_reset();
    mem_req = 1'b1;
    for (int k = 0; k < TIMEOUT; k++) step("timeout_busy");
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) step("timeout_err");
    idle_inputs();
    do_reset();
    step("after_err_reset");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline stall/flush controller for the five-stage MIPS-DLX core. It drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers and the PC register. It resolves three conditions:
- load-use hazards, with a configurable load latency;
- taken-branch squash;
- data-memory wait states, guarded by a watchdog that locks the pipeline on timeout.

## Interface
- LOAD_LAT, 1: stall cycles per load-use hazard; legal range 1..4.
- MEM_TIMEOUT, 16: maximum consecutive busy cycles before error; minimum 2.
- REG_W, 5: register-specifier width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low.
- id_rs, id_rt  in  REG_W  source specifiers of the instruction in ID.
- id_uses_rs, id_uses_rt  in  1  ID instruction reads rs / rt.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rt  in  REG_W  load destination in EX.
- branch_taken  in  1  branch resolved taken in ID.
- mem_req, mem_ready  in  1  data-memory access in MEM / access complete.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1  stage-register enables.
- ifid_flush, idex_flush  out  1  insert bubble into IF/ID / ID/EX.
- mem_err  out  1  watchdog tripped; sticky.
- stall_count  out  32  stall-cycle counter (see Configuration).

## Operation
Internal signals:
- hz = ex_mem_read & (ex_rt != 0) & ((id_uses_rs & id_rs == ex_rt) | (id_uses_rt & id_rt == ex_rt)).
- busy = mem_req & ~mem_ready.

States are RUN, LOAD_STALL, MEM_WAIT and ERROR. Outputs are Mealy (combinational from state and inputs). Unless a rule below says otherwise, all enables are 1 and both flushes are 0.

**Priority:** busy > hz/LOAD_STALL > branch_taken.

**Freeze** (busy in RUN/LOAD_STALL, or busy in MEM_WAIT):
- All five enables are 0 and both flushes are 0.
- In RUN/LOAD_STALL, next state is MEM_WAIT. The return state (RUN or LOAD_STALL) is saved, tmr is set to 1, and cnt holds.

**Stall** (hz in RUN, or any non-busy cycle in LOAD_STALL):
- pc_en = 0, ifid_en = 0, idex_flush = 1. All other outputs keep their defaults.
- branch_taken is ignored.

**RUN transitions:**
- hz with LOAD_LAT > 1: cnt <= LOAD_LAT-1, next state LOAD_STALL.
- hz with LOAD_LAT = 1: stay in RUN.
- branch_taken without hz: ifid_flush = 1 for that cycle.

**LOAD_STALL:** while not busy, cnt decrements each cycle. When cnt == 1, next state is RUN. Total stall cycles per hazard is exactly LOAD_LAT.

**MEM_WAIT:**
- busy and tmr == MEM_TIMEOUT-1: next state ERROR.
- busy otherwise: tmr increments.
- ~busy: outputs follow the saved return state's rules for that cycle, and next state is the return state.

**ERROR:** all enables 0, flushes 0, mem_err = 1. Exit is by reset only.

## Timing
- Outputs respond in the same cycle as their inputs; there is no output registering.
- State, cnt and tmr update on the rising edge of clk.
- While reset is low, every output is forced to 0 (including stall_count), state is RUN, and cnt = tmr = 0.
- After release, the first cycle is in RUN with all enables at 1.
- Reset asserted mid-stall or mid-wait aborts immediately; no saved context survives.
- Sequence N consecutive busy cycles starting in RUN (N < MEM_TIMEOUT): exactly N freeze cycles, then resume.
- Sequence MEM_TIMEOUT consecutive busy cycles: ERROR from the next edge.

## Configuration
- Macro PIPE_CTRL_PERF_CNT_EN defined: stall_count increments each cycle in which pc_en = 0 and reset is high. This includes freeze cycles and ERROR cycles. The counter saturates at 32'hFFFF_FFFF.
- Macro not defined: stall_count is tied to 0 and no counter register exists.

## Structure
- Package pipe_ctrl_pkg holds:
  - state enumeration and 2-bit encoding (RUN = 0, LOAD_STALL = 1, MEM_WAIT = 2, ERROR = 3);
  - REG_W;
  - the widths of cnt and tmr, derived with $clog2 of LOAD_LAT and MEM_TIMEOUT.
- One combinational sub-module, lu_detect, computes hz from the ID and EX fields. The FSM, counters and output decode stay in pipe_ctrl.

## Test plan
- **Reset:** reset = 0 drives all outputs to 0. After release, the five enables are 1, flushes are 0, and stall_count = 0.
- **Load-use, LOAD_LAT = 1:** ex_mem_read = 1, ex_rt = 8, id_rs = 8, id_uses_rs = 1 gives one cycle of pc_en = ifid_en = 0 with idex_flush = 1. Repeat with ex_rt = 0: no stall.
- **Load-use, LOAD_LAT = 3:** the same hazard gives exactly 3 stall cycles. branch_taken = 1 held throughout produces ifid_flush = 0 in all three.
- **Branch:** branch_taken = 1 in RUN with no hazard gives ifid_flush = 1 for one cycle, pc_en = 1, idex_flush = 0.
- **Memory wait and timeout:**
  - busy for 5 cycles, then ready: 5 freeze cycles, enables return to 1.
  - busy during LOAD_STALL: the stall remainder resumes after ready.
  - MEM_TIMEOUT = 16 with 16 busy cycles: mem_err = 1 from cycle 17, held until reset.
- **Perf counter:** with PIPE_CTRL_PERF_CNT_EN, the LOAD_LAT = 3 scenario plus a 5-cycle wait gives stall_count = 8. Without the macro, stall_count stays 0.
